// File: rtl/sequenciador_programa_if.sv
// ----------------------------------------------------------------------------
// sequenciador_programa_if
// Bundle between the program sequencer, its instruction ROM and the
// multicycle processor.
//   i_start       : begin execution from address 0
//   i_rom_data    : ROM word at o_addr (asynchronous read)
//   i_done        : processor instruction-complete flag
//   o_addr        : ROM address (program counter)
//   o_din         : word presented to the processor DIN port
//   o_run         : one-cycle pulse per issued instruction
//   o_busy        : fetching, issuing or waiting on the processor
//   o_halted      : stopped on a HALT word
//   o_error       : processor did not answer within the timeout
//   o_instr_count : retired instructions, saturating at 255
// master = sequencer side, slave = environment (ROM + processor) side.
// ----------------------------------------------------------------------------
interface sequenciador_programa_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              i_start;
    logic [15:0]       i_rom_data;
    logic              i_done;
    logic [ADDR_W-1:0] o_addr;
    logic [15:0]       o_din;
    logic              o_run;
    logic              o_busy;
    logic              o_halted;
    logic              o_error;
    logic [7:0]        o_instr_count;

    modport master (
        input  i_start, i_rom_data, i_done,
        output o_addr, o_din, o_run, o_busy, o_halted, o_error, o_instr_count
    );

    modport slave (
        output i_start, i_rom_data, i_done,
        input  o_addr, o_din, o_run, o_busy, o_halted, o_error, o_instr_count
    );
endinterface

// File: rtl/sequenciador_programa.sv
// ----------------------------------------------------------------------------
// sequenciador_programa
// Fetches 16-bit instructions from an asynchronous-read ROM, hands each one
// to the multicycle processor with a one-cycle Run pulse (plus the immediate
// word for mvi), waits for Done, counts retired instructions and stops on a
// HALT word (opcode 111) or when the processor fails to answer in time.
// Ports:
//   i_clock  : rising-edge clock
//   i_resetn : asynchronous active-low reset
//   io_bus   : sequenciador_programa_if master modport (start, ROM, processor)
// Parameters:
//   ADDR_W   : ROM address width; PC wraps modulo 2**ADDR_W
//   TIMEOUT  : maximum WAIT cycles allowed for Done before ERROR
// ----------------------------------------------------------------------------
module sequenciador_programa #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                   i_clock,
    input  logic                   i_resetn,
    sequenciador_programa_if.master io_bus
);

    localparam int unsigned     WaitW   = $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);
    localparam logic [2:0]      OpMvi   = 3'b001;
    localparam logic [2:0]      OpHalt  = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StIssue,
        StWait,
        StHalted,
        StError
    } state_e;

    state_e            r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [15:0]       r_din, w_din_next;
    logic [2:0]        r_op, w_op_next;
    logic [7:0]        r_count, w_count_next;
    logic [WaitW-1:0]  r_wait, w_wait_next;
    logic              w_is_halt;

    assign w_is_halt = (io_bus.i_rom_data[8:6] == OpHalt);

    // State register
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_pc    <= '0;
            r_din   <= '0;
            r_op    <= '0;
            r_count <= '0;
            r_wait  <= '0;
        end else begin
            r_pc    <= w_pc_next;
            r_din   <= w_din_next;
            r_op    <= w_op_next;
            r_count <= w_count_next;
            r_wait  <= w_wait_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle, StHalted, StError: begin
                if (io_bus.i_start) w_state_next = StFetch;
            end
            StFetch: w_state_next = w_is_halt ? StHalted : StIssue;
            StIssue: w_state_next = StWait;
            StWait: begin
                // Done wins over a timeout on the same edge
                if (io_bus.i_done) begin
                    w_state_next = StFetch;
                end else if (r_wait == WaitMax) begin
                    w_state_next = StError;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath next values
    always_comb begin
        w_pc_next    = r_pc;
        w_din_next   = r_din;
        w_op_next    = r_op;
        w_count_next = r_count;
        w_wait_next  = r_wait;
        case (r_state)
            StIdle, StHalted, StError: begin
                if (io_bus.i_start) begin
                    w_pc_next    = '0;
                    w_count_next = '0;
                end
            end
            StFetch: begin
                // A HALT word leaves PC, DIN and the count untouched
                if (!w_is_halt) begin
                    w_din_next = io_bus.i_rom_data;
                    w_op_next  = io_bus.i_rom_data[8:6];
                    w_pc_next  = r_pc + ADDR_W'(1);
                end
            end
            StIssue: begin
                // mvi: the immediate follows the opcode and is held through T1
                if (r_op == OpMvi) begin
                    w_din_next = io_bus.i_rom_data;
                    w_pc_next  = r_pc + ADDR_W'(1);
                end
                w_wait_next = WaitW'(1);
            end
            StWait: begin
                if (io_bus.i_done) begin
                    if (r_count != 8'hFF) w_count_next = r_count + 8'd1;
                end else if (r_wait != WaitMax) begin
                    w_wait_next = r_wait + WaitW'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs: registers or decodes of the state register only
    always_comb begin
        io_bus.o_addr        = r_pc;
        io_bus.o_din         = r_din;
        io_bus.o_instr_count = r_count;
        io_bus.o_run         = (r_state == StIssue);
        io_bus.o_busy        = (r_state == StFetch) || (r_state == StIssue) ||
                               (r_state == StWait);
        io_bus.o_halted      = (r_state == StHalted);
        io_bus.o_error       = (r_state == StError);
    end

endmodule
